// File: rtl/systolic_feeder_if.sv
// Load handshake and array-facing buses of the systolic feeder.
// The master side supplies operand beats; the slave side is the feeder itself.
interface systolic_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_a;
    logic [N*DATA_WIDTH-1:0] in_b;
    logic                    pe_clr;
    logic [N*DATA_WIDTH-1:0] a_row;
    logic [N*DATA_WIDTH-1:0] b_col;
    logic                    busy;
    logic                    done;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, pe_clr, a_row, b_col, busy, done
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, pe_clr, a_row, b_col, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers one A and one B matrix, then streams them diagonally skewed and
// zero-padded into an NxN systolic array, framed by a clear pulse and a done strobe.
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_feeder_if.slave   bus
);
    localparam int KW = $clog2(N + 1);
    localparam int TW = $clog2(3 * N - 1);
    localparam int LW = N * DATA_WIDTH;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef enum logic [1:0] {LOAD, CLEAR, FEED, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [KW-1:0]   r_k, w_k_nxt;
    logic [TW-1:0]   r_t, w_t_nxt;
    logic            w_accept;

    logic [DATA_WIDTH-1:0] r_a [N][N];
    logic [DATA_WIDTH-1:0] r_b [N][N];

    logic            r_in_ready, r_pe_clr, r_busy, r_done;
    logic [LW-1:0]   r_a_row, r_b_col;
    logic [LW-1:0]   w_a_skew, w_b_skew;

    assign w_accept = (r_state == LOAD) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_k     <= '0;
            r_t     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_t     <= w_t_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_t_nxt     = r_t;
        case (r_state)
            LOAD: begin
                if (bus.in_valid) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = CLEAR;
                        w_k_nxt     = '0;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            CLEAR: begin
                w_state_nxt = FEED;
                w_t_nxt     = '0;
            end
            FEED: begin
                if (r_t == T_LAST) w_state_nxt = DONE;
                else               w_t_nxt     = r_t + 1'b1;
            end
            DONE: begin
                w_state_nxt = LOAD;
                w_k_nxt     = '0;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // Beat k carries column k of A and row k of B.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int kk = 0; kk < N; kk++) begin
                if (r_k == KW'(kk)) begin
                    for (int i = 0; i < N; i++) begin
                        r_a[i][kk] <= bus.in_a[i*DATA_WIDTH +: DATA_WIDTH];
                        r_b[kk][i] <= bus.in_b[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Lane i of a carries A[i][t-i]; lane j of b carries B[t-j][j]; zero outside the diagonal band.
    always_comb begin
        w_a_skew = '0;
        w_b_skew = '0;
        for (int i = 0; i < N; i++) begin
            for (int kk = 0; kk < N; kk++) begin
                if (int'(w_t_nxt) == i + kk) begin
                    w_a_skew[i*DATA_WIDTH +: DATA_WIDTH] = r_a[i][kk];
                    w_b_skew[i*DATA_WIDTH +: DATA_WIDTH] = r_b[kk][i];
                end
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
            r_pe_clr   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_a_row    <= '0;
            r_b_col    <= '0;
        end else begin
            r_in_ready <= (w_state_nxt == LOAD);
            r_pe_clr   <= (w_state_nxt == CLEAR);
            r_busy     <= (w_state_nxt != LOAD);
            r_done     <= (w_state_nxt == DONE);
            r_a_row    <= (w_state_nxt == FEED) ? w_a_skew : '0;
            r_b_col    <= (w_state_nxt == FEED) ? w_b_skew : '0;
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.pe_clr   = r_pe_clr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.a_row    = r_a_row;
    assign bus.b_col    = r_b_col;
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder: checks skew/padding lane by lane against the
// matrices and checks that an ideal systolic array fed from the streams yields A*B.
module tb_systolic_feeder;
    localparam int DW     = 8;
    localparam int N      = 4;
    localparam int LW     = N * DW;
    localparam int T_FEED = 3 * N - 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();
    systolic_feeder    #(.DATA_WIDTH(DW), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int edge_count = 0;
    int ma [N][N];
    int mb [N][N];
    int cap_a [T_FEED][N];
    int cap_b [T_FEED][N];

    task automatic step();
        @(posedge clk);
        #1;
        edge_count++;
    endtask

    function automatic int lane(input logic [LW-1:0] v, input int i);
        return int'(v[i*DW +: DW]);
    endfunction

    function automatic int exp_a(input int t, input int i);
        int k = t - i;
        if (k >= 0 && k < N) return ma[i][k];
        return 0;
    endfunction

    function automatic int exp_b(input int t, input int j);
        int k = t - j;
        if (k >= 0 && k < N) return mb[k][j];
        return 0;
    endfunction

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = int'($urandom_range(hi, lo));
                mb[i][j] = int'($urandom_range(hi, lo));
            end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < N; i++) begin
            bus.in_a[i*DW +: DW] = DW'(ma[i][k]);
            bus.in_b[i*DW +: DW] = DW'(mb[k][i]);
        end
    endtask

    // One full product: load (optionally with toggling valid), clear, feed, done, back to LOAD.
    task automatic run_product(input bit toggle_valid, input bit poke_feed,
                               output int lat, output int first_edge);
        int k = 0;
        int guard = 0;
        bit started = 0;
        bit acc;
        logic [LW-1:0] ea, eb;
        lat = 0;
        first_edge = -1;
        while (k < N && guard < 100) begin
            bus.in_valid = toggle_valid ? ((guard % 2) == 0) : 1'b1;
            drive_beat(k);
            acc = bus.in_valid && bus.in_ready;
            step();
            guard++;
            if (acc && !started) first_edge = edge_count;
            if (acc || started) lat++;
            if (acc) begin
                started = 1;
                k++;
            end
            if (k < N) begin
                checks++;
                if (bus.in_ready !== 1'b1 || bus.pe_clr !== 1'b0 || bus.a_row !== '0) begin
                    errors++;
                    $display("FAIL load_state: in_ready=%b pe_clr=%b a_row=%h, want 1 0 0",
                             bus.in_ready, bus.pe_clr, bus.a_row);
                end
            end
        end
        checks++;
        if (k != N) begin
            errors++;
            $display("FAIL load_timeout: accepted %0d beats, want %0d", k, N);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.pe_clr !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
            bus.a_row !== '0 || bus.b_col !== '0) begin
            errors++;
            $display("FAIL clear_cycle: pe_clr=%b in_ready=%b busy=%b a=%h b=%h, want 1 0 1 0 0",
                     bus.pe_clr, bus.in_ready, bus.busy, bus.a_row, bus.b_col);
        end
        for (int t = 0; t < T_FEED; t++) begin
            if (poke_feed) begin
                bus.in_valid = 1'($urandom_range(1, 0));
                bus.in_a     = LW'($urandom);
                bus.in_b     = LW'($urandom);
            end
            step();
            lat++;
            for (int i = 0; i < N; i++) begin
                ea[i*DW +: DW] = DW'(exp_a(t, i));
                eb[i*DW +: DW] = DW'(exp_b(t, i));
                cap_a[t][i] = lane(bus.a_row, i);
                cap_b[t][i] = lane(bus.b_col, i);
            end
            checks++;
            if (bus.a_row !== ea || bus.b_col !== eb) begin
                errors++;
                $display("FAIL feed_t%0d: a=%h b=%h, want a=%h b=%h", t, bus.a_row, bus.b_col, ea, eb);
            end
            checks++;
            if (bus.pe_clr !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL feed_ctrl_t%0d: pe_clr=%b done=%b busy=%b in_ready=%b, want 0 0 1 0",
                         t, bus.pe_clr, bus.done, bus.busy, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        step();
        lat++;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.a_row !== '0 || bus.b_col !== '0) begin
            errors++;
            $display("FAIL done_cycle: done=%b busy=%b a=%h b=%h, want 1 1 0 0",
                     bus.done, bus.busy, bus.a_row, bus.b_col);
        end
        // Ideal array: PE(i,j) multiplies a lane i delayed j hops with b lane j delayed i hops.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int got = 0;
                int want = 0;
                for (int tt = 0; tt < T_FEED; tt++)
                    if (tt - j >= 0 && tt - i >= 0)
                        got += cap_a[tt - j][i] * cap_b[tt - i][j];
                for (int kk = 0; kk < N; kk++) want += ma[i][kk] * mb[kk][j];
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL c_out[%0d][%0d]: got %0d, want %0d", i, j, got, want);
                end
            end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b in_ready=%b busy=%b, want 0 1 0",
                     bus.done, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.pe_clr !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.a_row !== '0 || bus.b_col !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b clr=%b busy=%b done=%b a=%h b=%h",
                     bus.in_ready, bus.pe_clr, bus.busy, bus.done, bus.a_row, bus.b_col);
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_known_and_latency();
        int lat, fe;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = i * N + j + 1;
                mb[i][j] = 100 + i * N + j;
            end
        run_product(1'b0, 1'b0, lat, fe);
        // 4N cycles inclusive from first-beat cycle to done cycle = 4N-1 edges.
        checks++;
        if (lat !== 4 * N - 1) begin
            errors++;
            $display("FAIL latency: %0d edges, want %0d", lat, 4 * N - 1);
        end
    endtask

    task automatic test_random();
        int lat, fe;
        for (int r = 0; r < 3; r++) begin
            fill_random(0, 255);
            run_product(1'b0, (r % 2) == 1, lat, fe);
        end
    endtask

    task automatic test_backpressure();
        int lat, fe;
        fill_random(0, 255);
        run_product(1'b1, 1'b1, lat, fe);
    endtask

    task automatic test_full_scale();
        int lat, fe;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 255;
                mb[i][j] = 255;
            end
        run_product(1'b0, 1'b0, lat, fe);
        checks++;
        if (cap_a[N-1][0] * cap_b[N-1][0] * N !== 260100 || ma[0][0] * mb[0][0] * N !== 260100) begin
            errors++;
            $display("FAIL full_scale: lane product %0d, want 260100", cap_a[N-1][0] * cap_b[N-1][0] * N);
        end
    endtask

    task automatic test_back_to_back();
        int lat, fe1, fe2;
        fill_random(0, 255);
        run_product(1'b0, 1'b0, lat, fe1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) ma[i][j] = (i == j) ? 1 : 0;
        run_product(1'b0, 1'b0, lat, fe2);
        checks++;
        if (fe2 - fe1 !== 4 * N) begin
            errors++;
            $display("FAIL throughput: %0d edges between products, want %0d", fe2 - fe1, 4 * N);
        end
    endtask

    task automatic test_reset_mid();
        int lat, fe;
        fill_random(1, 255);
        for (int k = 0; k < N; k++) begin
            bus.in_valid = 1'b1;
            drive_beat(k);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if (bus.busy !== 1'b1 || lane(bus.a_row, 0) !== ma[0][2]) begin
            errors++;
            $display("FAIL mid_feed: busy=%b a0=%0d, want 1 %0d", bus.busy, lane(bus.a_row, 0), ma[0][2]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.pe_clr !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.a_row !== '0 || bus.b_col !== '0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b clr=%b busy=%b done=%b a=%h b=%h",
                     bus.in_ready, bus.pe_clr, bus.busy, bus.done, bus.a_row, bus.b_col);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pe_clr !== 1'b0) begin
            errors++;
            $display("FAIL post_abort: in_ready=%b busy=%b pe_clr=%b, want 1 0 0",
                     bus.in_ready, bus.busy, bus.pe_clr);
        end
        fill_random(0, 255);
        run_product(1'b0, 1'b0, lat, fe);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        test_reset();
        test_known_and_latency();
        test_random();
        test_backpressure();
        test_full_scale();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the N×N systolic PE array.
- Buffers one A operand matrix and one B operand matrix, loaded as N beats over a valid/ready interface.
- Streams them into the array's left edge (a lanes) and top edge (b lanes) with diagonal skew and zero padding.
- Pulses a clear to the PE accumulators before streaming, and a done strobe once every PE's c_out holds the final dot product.

Parameters:
DATA_WIDTH, 8, element width; matches the PE.
N, 4, array dimension (rows = cols = N), N >= 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  load beat valid.
in_ready  out  1  high while in LOAD; beat accepted when in_valid && in_ready.
in_a  in  N*DATA_WIDTH  beat k: lane i = A[i][k].
in_b  in  N*DATA_WIDTH  beat k: lane j = B[k][j].
pe_clr  out  1  one-cycle active-high synchronous clear for the PE array's rst input.
a_row  out  N*DATA_WIDTH  lane i drives a_in of PE(i,0).
b_col  out  N*DATA_WIDTH  lane j drives b_in of PE(0,j).
busy  out  1  high in CLEAR, FEED and DONE.
done  out  1  one-cycle pulse; all PE c_out values are final in this cycle.

Behaviour:
- Lane i of every bus occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- All outputs are registered.
- Reset (async, rst_n low):
  - state = LOAD; beat counter k = 0; feed counter t = 0.
  - in_ready = 1; pe_clr = 0; busy = 0; done = 0.
  - a_row = 0; b_col = 0.
  - Buffer contents need not be cleared.
- Reset mid-operation (any state) aborts immediately with no completion of the stream. The array must be re-cleared by the next CLEAR.
- LOAD:
  - Each accepted beat writes column k of A and row k of B into the buffers, then k++.
  - in_valid low: hold; no counter change.
  - Accepting beat N-1 → CLEAR next cycle; in_ready drops in the same edge, so no beat N is accepted.
  - a_row and b_col stay 0.
- CLEAR (1 cycle):
  - pe_clr = 1; a_row = 0; b_col = 0.
  - → FEED with t = 0.
- FEED (exactly 3N-2 cycles, t = 0..3N-3):
  - a_row lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_col lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Zero padding is mandatory because the PE accumulates every product.
  - After t = 3N-3 → DONE.
- DONE (1 cycle):
  - done = 1; a_row = 0; b_col = 0.
  - Rationale: the last product enters PE(N-1,N-1) at t = 3N-3, and its c_out is valid after that edge.
  - → LOAD with k = 0.
- in_valid asserted outside LOAD is ignored; no buffer writes.
- Back-to-back operation: a beat may be accepted in the first LOAD cycle after DONE.
- Counter widths:
  - k: clog2(N+1).
  - t: clog2(3N-1).
  - No wrap-around beyond the stated terminal counts.
- Throughput: one matrix product per N + 1 + (3N-2) + 1 = 4N cycles, assuming in_valid is held high.

Test Plan:
- Reset values: assert rst_n low mid-FEED → all outputs take reset values asynchronously, before the next edge. After release: in_ready = 1, busy = 0.
- Skew/padding, N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:
  - beats: in_a = {3,1} then {4,2}; in_b = {6,5} then {8,7}.
  - pe_clr for 1 cycle, then FEED:
  - t0: a = (1,0), b = (5,0).
  - t1: a = (2,3), b = (7,6).
  - t2: a = (0,4), b = (0,8).
  - t3: a = (0,0), b = (0,0).
  - then done pulse.
- End-to-end with a 2×2 PE array: the stimulus above → c_out = [[19,22],[43,50]] in the done cycle. Second back-to-back product (A = I, B same) → [[5,6],[7,8]], proving pe_clr cleared the accumulators.
- Load backpressure, N=4: toggle in_valid 1,0,1,0,... → exactly 4 beats accepted. CLEAR follows the 4th acceptance. An in_valid pulse during FEED changes neither the buffers nor the outputs.
- Full-scale values, N=4: all elements 255 → every FEED lane is 255 or 0 per the skew rule. The 4×4 array yields 4*255*255 = 260100 in every c_out at done.
- Latency check, N=4: 16 cycles from the first accepted beat to the done pulse with continuous in_valid (4 LOAD + 1 CLEAR + 10 FEED + 1 DONE).
